// File: rtl/speicher_steuerung.sv
// Memory controller arbitrating CPU fetch and load/store ports onto one variable-latency memory.
// Optional single-entry fetch buffer enabled by defining INSTRUKTIONS_PUFFER_EN.
module speicher_steuerung #(
    parameter int unsigned ADR_BREITE = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [31:0]           InstruktionAdresse,
    input  logic                  LeseInstruktion,
    output logic [31:0]           Instruktion,
    output logic                  InstruktionGeladen,
    input  logic [31:0]           DatenAdresse,
    input  logic [31:0]           DatenRaus,
    input  logic                  LeseDaten,
    input  logic                  SchreibeDaten,
    output logic [31:0]           DatenRein,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic [ADR_BREITE-1:0] SpeicherAdresse,
    output logic [31:0]           SpeicherDatenSchreiben,
    input  logic [31:0]           SpeicherDatenLesen,
    output logic                  SpeicherLesen,
    output logic                  SpeicherSchreiben,
    input  logic                  SpeicherBereit,
    output logic                  Fehler
);

    typedef enum logic [1:0] {StLeerlauf, StLesen, StSchreiben, StFertig} zustand_e;
    typedef enum logic [1:0] {ArtInstr, ArtLaden, ArtSpeichern} art_e;

    localparam logic [15:0] ZaehlerMax = 16'(TIMEOUT - 1);

    zustand_e              zustand_q;
    art_e                  art_q;
    art_e                  art_wahl;
    logic [31:0]           adr_wahl;
    logic                  anfrage;
    logic                  ausser_bereich;
    logic                  puf_treffer;
    logic [31:0]           puf_daten;
    logic [15:0]           zaehler_q;
    logic [ADR_BREITE-1:0] adr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           instr_q;
    logic [31:0]           daten_q;
    logic                  lesen_q;
    logic                  schreiben_q;
    logic                  instr_geladen_q;
    logic                  daten_geladen_q;
    logic                  daten_gespeichert_q;
    logic                  fehler_q;

    // Fixed priority: store, then load, then fetch.
    always_comb begin
        art_wahl = ArtInstr;
        adr_wahl = InstruktionAdresse;
        anfrage  = LeseInstruktion;
        if (SchreibeDaten) begin
            art_wahl = ArtSpeichern;
            adr_wahl = DatenAdresse;
            anfrage  = 1'b1;
        end else if (LeseDaten) begin
            art_wahl = ArtLaden;
            adr_wahl = DatenAdresse;
            anfrage  = 1'b1;
        end
    end

    assign ausser_bereich = (adr_wahl >> ADR_BREITE) != 32'd0;

`ifdef INSTRUKTIONS_PUFFER_EN
    logic        puf_gueltig_q;
    logic [31:0] puf_tag_q;
    logic [31:0] puf_daten_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            puf_gueltig_q <= 1'b0;
            puf_tag_q     <= '0;
            puf_daten_q   <= '0;
        end else if (zustand_q == StLesen && art_q == ArtInstr) begin
            if (SpeicherBereit) begin
                puf_gueltig_q <= 1'b1;
                puf_tag_q     <= 32'(adr_q);
                puf_daten_q   <= SpeicherDatenLesen;
            end else if (zaehler_q == ZaehlerMax) begin
                puf_gueltig_q <= 1'b0;
            end
        end else if (zustand_q == StLeerlauf && SchreibeDaten && DatenAdresse == puf_tag_q) begin
            puf_gueltig_q <= 1'b0;
        end
    end

    // Tag only ever holds in-range addresses, so a hit is never out of range.
    assign puf_treffer = (art_wahl == ArtInstr) && puf_gueltig_q && (puf_tag_q == adr_wahl);
    assign puf_daten   = puf_daten_q;
`else
    assign puf_treffer = 1'b0;
    assign puf_daten   = '0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zustand_q           <= StLeerlauf;
            art_q               <= ArtInstr;
            zaehler_q           <= '0;
            adr_q               <= '0;
            wdata_q             <= '0;
            instr_q             <= '0;
            daten_q             <= '0;
            lesen_q             <= 1'b0;
            schreiben_q         <= 1'b0;
            instr_geladen_q     <= 1'b0;
            daten_geladen_q     <= 1'b0;
            daten_gespeichert_q <= 1'b0;
            fehler_q            <= 1'b0;
        end else begin
            instr_geladen_q     <= 1'b0;
            daten_geladen_q     <= 1'b0;
            daten_gespeichert_q <= 1'b0;
            unique case (zustand_q)
                StLeerlauf: begin
                    if (anfrage) begin
                        art_q     <= art_wahl;
                        adr_q     <= adr_wahl[ADR_BREITE-1:0];
                        wdata_q   <= DatenRaus;
                        zaehler_q <= '0;
                        if (ausser_bereich || puf_treffer) begin
                            zustand_q           <= StFertig;
                            instr_geladen_q     <= (art_wahl == ArtInstr);
                            daten_geladen_q     <= (art_wahl == ArtLaden);
                            daten_gespeichert_q <= (art_wahl == ArtSpeichern);
                            if (ausser_bereich) fehler_q <= 1'b1;
                            if (art_wahl == ArtInstr) instr_q <= ausser_bereich ? '0 : puf_daten;
                            if (art_wahl == ArtLaden) daten_q <= '0;
                        end else if (art_wahl == ArtSpeichern) begin
                            schreiben_q <= 1'b1;
                            zustand_q   <= StSchreiben;
                        end else begin
                            lesen_q   <= 1'b1;
                            zustand_q <= StLesen;
                        end
                    end
                end
                StLesen, StSchreiben: begin
                    // Ready in the last allowed cycle still counts as success.
                    if (SpeicherBereit || zaehler_q == ZaehlerMax) begin
                        lesen_q             <= 1'b0;
                        schreiben_q         <= 1'b0;
                        zustand_q           <= StFertig;
                        instr_geladen_q     <= (art_q == ArtInstr);
                        daten_geladen_q     <= (art_q == ArtLaden);
                        daten_gespeichert_q <= (art_q == ArtSpeichern);
                        if (!SpeicherBereit) fehler_q <= 1'b1;
                        if (art_q == ArtInstr) instr_q <= SpeicherBereit ? SpeicherDatenLesen : '0;
                        if (art_q == ArtLaden) daten_q <= SpeicherBereit ? SpeicherDatenLesen : '0;
                    end else begin
                        zaehler_q <= zaehler_q + 16'd1;
                    end
                end
                StFertig: zustand_q <= StLeerlauf;
                default:  zustand_q <= StLeerlauf;
            endcase
        end
    end

    assign Instruktion            = instr_q;
    assign InstruktionGeladen     = instr_geladen_q;
    assign DatenRein              = daten_q;
    assign DatenGeladen           = daten_geladen_q;
    assign DatenGespeichert       = daten_gespeichert_q;
    assign SpeicherAdresse        = adr_q;
    assign SpeicherDatenSchreiben = wdata_q;
    assign SpeicherLesen          = lesen_q;
    assign SpeicherSchreiben      = schreiben_q;
    assign Fehler                 = fehler_q;

endmodule

// File: tb/tb_speicher_steuerung.sv
// Directed self-checking bench for speicher_steuerung; a second instance with TIMEOUT=4
// exercises the access timeout.
module tb_speicher_steuerung;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] InstruktionAdresse;
    logic        LeseInstruktion;
    logic [31:0] Instruktion;
    logic        InstruktionGeladen;
    logic [31:0] DatenAdresse;
    logic [31:0] DatenRaus;
    logic        LeseDaten;
    logic        SchreibeDaten;
    logic [31:0] DatenRein;
    logic        DatenGeladen;
    logic        DatenGespeichert;
    logic [15:0] SpeicherAdresse;
    logic [31:0] SpeicherDatenSchreiben;
    logic [31:0] SpeicherDatenLesen;
    logic        SpeicherLesen;
    logic        SpeicherSchreiben;
    logic        SpeicherBereit;
    logic        Fehler;

    logic        t_lese_daten;
    logic [31:0] t_daten_adresse;
    logic        t_bereit;
    logic [31:0] t_instruktion;
    logic        t_instruktion_geladen;
    logic [31:0] t_daten_rein;
    logic        t_daten_geladen;
    logic        t_daten_gespeichert;
    logic [15:0] t_speicher_adresse;
    logic [31:0] t_speicher_daten_schreiben;
    logic        t_speicher_lesen;
    logic        t_speicher_schreiben;
    logic        t_fehler;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    speicher_steuerung dut (
        .Clock                  (Clock),
        .Reset                  (Reset),
        .InstruktionAdresse     (InstruktionAdresse),
        .LeseInstruktion        (LeseInstruktion),
        .Instruktion            (Instruktion),
        .InstruktionGeladen     (InstruktionGeladen),
        .DatenAdresse           (DatenAdresse),
        .DatenRaus              (DatenRaus),
        .LeseDaten              (LeseDaten),
        .SchreibeDaten          (SchreibeDaten),
        .DatenRein              (DatenRein),
        .DatenGeladen           (DatenGeladen),
        .DatenGespeichert       (DatenGespeichert),
        .SpeicherAdresse        (SpeicherAdresse),
        .SpeicherDatenSchreiben (SpeicherDatenSchreiben),
        .SpeicherDatenLesen     (SpeicherDatenLesen),
        .SpeicherLesen          (SpeicherLesen),
        .SpeicherSchreiben      (SpeicherSchreiben),
        .SpeicherBereit         (SpeicherBereit),
        .Fehler                 (Fehler)
    );

    speicher_steuerung #(.ADR_BREITE(16), .TIMEOUT(4)) dut_to (
        .Clock                  (Clock),
        .Reset                  (Reset),
        .InstruktionAdresse     (32'd0),
        .LeseInstruktion        (1'b0),
        .Instruktion            (t_instruktion),
        .InstruktionGeladen     (t_instruktion_geladen),
        .DatenAdresse           (t_daten_adresse),
        .DatenRaus              (32'd0),
        .LeseDaten              (t_lese_daten),
        .SchreibeDaten          (1'b0),
        .DatenRein              (t_daten_rein),
        .DatenGeladen           (t_daten_geladen),
        .DatenGespeichert       (t_daten_gespeichert),
        .SpeicherAdresse        (t_speicher_adresse),
        .SpeicherDatenSchreiben (t_speicher_daten_schreiben),
        .SpeicherDatenLesen     (SpeicherDatenLesen),
        .SpeicherLesen          (t_speicher_lesen),
        .SpeicherSchreiben      (t_speicher_schreiben),
        .SpeicherBereit         (t_bereit),
        .Fehler                 (t_fehler)
    );

    task automatic test_reset();
        Reset = 1'b0;
        InstruktionAdresse = '0; LeseInstruktion = 1'b0; DatenAdresse = '0; DatenRaus = '0;
        LeseDaten = 1'b0; SchreibeDaten = 1'b0; SpeicherDatenLesen = '0; SpeicherBereit = 1'b0;
        t_lese_daten = 1'b0; t_daten_adresse = '0; t_bereit = 1'b0;
        repeat (2) @(negedge Clock);
        checks++; if (Instruktion !== 32'd0 || DatenRein !== 32'd0) begin errors++;
            $display("FAIL reset_results: got %h/%h want 0/0", Instruktion, DatenRein); end
        checks++; if ({InstruktionGeladen, DatenGeladen, DatenGespeichert} !== 3'b000) begin errors++;
            $display("FAIL reset_pulses: got %b want 000", {InstruktionGeladen, DatenGeladen, DatenGespeichert}); end
        checks++; if ({SpeicherLesen, SpeicherSchreiben, Fehler} !== 3'b000) begin errors++;
            $display("FAIL reset_strobes_fehler: got %b want 000", {SpeicherLesen, SpeicherSchreiben, Fehler}); end
        checks++; if (SpeicherAdresse !== 16'd0 || SpeicherDatenSchreiben !== 32'd0) begin errors++;
            $display("FAIL reset_mem_bus: got %h/%h want 0/0", SpeicherAdresse, SpeicherDatenSchreiben); end
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_fetch();
        InstruktionAdresse = 32'h10; LeseInstruktion = 1'b1;
        @(negedge Clock);
        checks++; if (SpeicherLesen !== 1'b1 || SpeicherAdresse !== 16'h0010) begin errors++;
            $display("FAIL fetch_strobe: got lesen=%b adr=%h want 1/0010", SpeicherLesen, SpeicherAdresse); end
        checks++; if (InstruktionGeladen !== 1'b0) begin errors++;
            $display("FAIL fetch_early_pulse: got %b want 0", InstruktionGeladen); end
        SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'hDEADBEEF;
        @(negedge Clock);
        checks++; if (InstruktionGeladen !== 1'b1 || Instruktion !== 32'hDEADBEEF) begin errors++;
            $display("FAIL fetch_done: got pulse=%b instr=%h want 1/deadbeef", InstruktionGeladen, Instruktion); end
        checks++; if (SpeicherLesen !== 1'b0) begin errors++;
            $display("FAIL fetch_strobe_drop: got %b want 0", SpeicherLesen); end
        SpeicherBereit = 1'b0; LeseInstruktion = 1'b0;
        @(negedge Clock);
        checks++; if (InstruktionGeladen !== 1'b0 || Instruktion !== 32'hDEADBEEF) begin errors++;
            $display("FAIL fetch_one_pulse: got pulse=%b instr=%h want 0/deadbeef", InstruktionGeladen, Instruktion); end
    endtask

    task automatic test_store_priority();
        InstruktionAdresse = 32'h50; LeseInstruktion = 1'b1;
        DatenAdresse = 32'h20; DatenRaus = 32'h12345678; SchreibeDaten = 1'b1;
        @(negedge Clock);
        checks++; if (SpeicherSchreiben !== 1'b1 || SpeicherLesen !== 1'b0) begin errors++;
            $display("FAIL prio_strobes: got schreiben=%b lesen=%b want 1/0", SpeicherSchreiben, SpeicherLesen); end
        checks++; if (SpeicherAdresse !== 16'h0020 || SpeicherDatenSchreiben !== 32'h12345678) begin errors++;
            $display("FAIL prio_bus: got %h/%h want 0020/12345678", SpeicherAdresse, SpeicherDatenSchreiben); end
        SpeicherBereit = 1'b1;
        @(negedge Clock);
        checks++; if (DatenGespeichert !== 1'b1 || InstruktionGeladen !== 1'b0 || SpeicherSchreiben !== 1'b0) begin
            errors++; $display("FAIL prio_store_done: got gesp=%b igel=%b schr=%b want 1/0/0",
                DatenGespeichert, InstruktionGeladen, SpeicherSchreiben); end
        SpeicherBereit = 1'b0; SchreibeDaten = 1'b0;
        @(negedge Clock);
        checks++; if (SpeicherLesen !== 1'b0 || DatenGespeichert !== 1'b0) begin errors++;
            $display("FAIL prio_fertig_idle: got lesen=%b gesp=%b want 0/0", SpeicherLesen, DatenGespeichert); end
        @(negedge Clock);
        checks++; if (SpeicherLesen !== 1'b1 || SpeicherAdresse !== 16'h0050) begin errors++;
            $display("FAIL prio_fetch_strobe: got lesen=%b adr=%h want 1/0050", SpeicherLesen, SpeicherAdresse); end
        SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'hCAFE0001;
        @(negedge Clock);
        checks++; if (InstruktionGeladen !== 1'b1 || Instruktion !== 32'hCAFE0001) begin errors++;
            $display("FAIL prio_fetch_done: got pulse=%b instr=%h want 1/cafe0001", InstruktionGeladen, Instruktion); end
        SpeicherBereit = 1'b0; LeseInstruktion = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_slow_load();
        DatenAdresse = 32'h30; LeseDaten = 1'b1;
        @(negedge Clock);
        for (int i = 0; i < 7; i++) begin
            checks++; if (SpeicherLesen !== 1'b1 || SpeicherAdresse !== 16'h0030 || DatenGeladen !== 1'b0) begin
                errors++; $display("FAIL slow_wait[%0d]: got lesen=%b adr=%h pulse=%b want 1/0030/0",
                    i, SpeicherLesen, SpeicherAdresse, DatenGeladen); end
            if (i == 6) begin SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'hA5A55A5A; end
            @(negedge Clock);
        end
        checks++; if (DatenGeladen !== 1'b1 || DatenRein !== 32'hA5A55A5A || SpeicherLesen !== 1'b0) begin
            errors++; $display("FAIL slow_done: got pulse=%b daten=%h lesen=%b want 1/a5a55a5a/0",
                DatenGeladen, DatenRein, SpeicherLesen); end
        checks++; if (Fehler !== 1'b0) begin errors++;
            $display("FAIL slow_no_fehler: got %b want 0", Fehler); end
        SpeicherBereit = 1'b0; LeseDaten = 1'b0;
        @(negedge Clock);
        checks++; if (DatenGeladen !== 1'b0) begin errors++;
            $display("FAIL slow_one_pulse: got %b want 0", DatenGeladen); end
    endtask

    task automatic test_out_of_range();
        DatenAdresse = 32'h0001_0000; LeseDaten = 1'b1;
        @(negedge Clock);
        checks++; if (DatenGeladen !== 1'b1 || SpeicherLesen !== 1'b0) begin errors++;
            $display("FAIL range_pulse: got pulse=%b lesen=%b want 1/0", DatenGeladen, SpeicherLesen); end
        checks++; if (DatenRein !== 32'd0 || Fehler !== 1'b1) begin errors++;
            $display("FAIL range_result: got daten=%h fehler=%b want 0/1", DatenRein, Fehler); end
        LeseDaten = 1'b0;
        @(negedge Clock);
        checks++; if (DatenGeladen !== 1'b0 || SpeicherLesen !== 1'b0) begin errors++;
            $display("FAIL range_after: got pulse=%b lesen=%b want 0/0", DatenGeladen, SpeicherLesen); end
    endtask

    task automatic test_puffer();
        InstruktionAdresse = 32'h40; LeseInstruktion = 1'b1;
        @(negedge Clock);
        SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'h0BADF00D;
        @(negedge Clock);
        checks++; if (InstruktionGeladen !== 1'b1 || Instruktion !== 32'h0BADF00D) begin errors++;
            $display("FAIL puf_first: got pulse=%b instr=%h want 1/0badf00d", InstruktionGeladen, Instruktion); end
        SpeicherBereit = 1'b0; LeseInstruktion = 1'b0;
        @(negedge Clock);
        LeseInstruktion = 1'b1;
        @(negedge Clock);
`ifdef INSTRUKTIONS_PUFFER_EN
        checks++; if (SpeicherLesen !== 1'b0 || InstruktionGeladen !== 1'b1 || Instruktion !== 32'h0BADF00D) begin
            errors++; $display("FAIL puf_hit: got lesen=%b pulse=%b instr=%h want 0/1/0badf00d",
                SpeicherLesen, InstruktionGeladen, Instruktion); end
        LeseInstruktion = 1'b0;
        @(negedge Clock);
`else
        checks++; if (SpeicherLesen !== 1'b1 || InstruktionGeladen !== 1'b0) begin errors++;
            $display("FAIL puf_none_refetch: got lesen=%b pulse=%b want 1/0", SpeicherLesen, InstruktionGeladen); end
        SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'h0BADF00E;
        @(negedge Clock);
        checks++; if (InstruktionGeladen !== 1'b1 || Instruktion !== 32'h0BADF00E) begin errors++;
            $display("FAIL puf_none_done: got pulse=%b instr=%h want 1/0badf00e", InstruktionGeladen, Instruktion); end
        SpeicherBereit = 1'b0; LeseInstruktion = 1'b0;
        @(negedge Clock);
`endif
        DatenAdresse = 32'h40; DatenRaus = 32'h99; SchreibeDaten = 1'b1;
        @(negedge Clock);
        SpeicherBereit = 1'b1;
        @(negedge Clock);
        checks++; if (DatenGespeichert !== 1'b1) begin errors++;
            $display("FAIL puf_store: got %b want 1", DatenGespeichert); end
        SpeicherBereit = 1'b0; SchreibeDaten = 1'b0;
        @(negedge Clock);
        LeseInstruktion = 1'b1;
        @(negedge Clock);
        checks++; if (SpeicherLesen !== 1'b1 || InstruktionGeladen !== 1'b0) begin errors++;
            $display("FAIL puf_after_store: got lesen=%b pulse=%b want 1/0", SpeicherLesen, InstruktionGeladen); end
        SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'h77777777;
        @(negedge Clock);
        checks++; if (InstruktionGeladen !== 1'b1 || Instruktion !== 32'h77777777) begin errors++;
            $display("FAIL puf_refill: got pulse=%b instr=%h want 1/77777777", InstruktionGeladen, Instruktion); end
        SpeicherBereit = 1'b0; LeseInstruktion = 1'b0;
        @(negedge Clock);
        checks++; if (Fehler !== 1'b1) begin errors++;
            $display("FAIL fehler_sticky: got %b want 1", Fehler); end
    endtask

    task automatic test_timeout();
        t_daten_adresse = 32'h30; t_lese_daten = 1'b1;
        @(negedge Clock);
        t_bereit = 1'b1; SpeicherDatenLesen = 32'h11112222;
        @(negedge Clock);
        checks++; if (t_daten_geladen !== 1'b1 || t_daten_rein !== 32'h11112222) begin errors++;
            $display("FAIL to_prep: got pulse=%b daten=%h want 1/11112222", t_daten_geladen, t_daten_rein); end
        t_bereit = 1'b0; t_lese_daten = 1'b0;
        @(negedge Clock);
        t_lese_daten = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            checks++; if (t_speicher_lesen !== 1'b1 || t_daten_geladen !== 1'b0) begin errors++;
                $display("FAIL to_wait[%0d]: got lesen=%b pulse=%b want 1/0", i, t_speicher_lesen, t_daten_geladen); end
        end
        @(negedge Clock);
        checks++; if (t_speicher_lesen !== 1'b0 || t_daten_geladen !== 1'b1) begin errors++;
            $display("FAIL to_abort: got lesen=%b pulse=%b want 0/1", t_speicher_lesen, t_daten_geladen); end
        checks++; if (t_daten_rein !== 32'd0 || t_fehler !== 1'b1) begin errors++;
            $display("FAIL to_result: got daten=%h fehler=%b want 0/1", t_daten_rein, t_fehler); end
        t_lese_daten = 1'b0;
        repeat (2) @(negedge Clock);
        checks++; if (t_fehler !== 1'b1 || t_daten_geladen !== 1'b0) begin errors++;
            $display("FAIL to_sticky: got fehler=%b pulse=%b want 1/0", t_fehler, t_daten_geladen); end
    endtask

    task automatic test_reset_mid_write();
        DatenAdresse = 32'h60; DatenRaus = 32'h55; SchreibeDaten = 1'b1;
        @(negedge Clock);
        checks++; if (SpeicherSchreiben !== 1'b1) begin errors++;
            $display("FAIL rst_write_active: got %b want 1", SpeicherSchreiben); end
        #2 Reset = 1'b0;
        SchreibeDaten = 1'b0;
        #1;
        checks++; if (SpeicherSchreiben !== 1'b0 || SpeicherAdresse !== 16'd0 || SpeicherDatenSchreiben !== 32'd0) begin
            errors++; $display("FAIL rst_async_bus: got schr=%b adr=%h wd=%h want 0/0/0",
                SpeicherSchreiben, SpeicherAdresse, SpeicherDatenSchreiben); end
        checks++; if (Fehler !== 1'b0 || Instruktion !== 32'd0 || DatenRein !== 32'd0) begin errors++;
            $display("FAIL rst_async_regs: got fehler=%b instr=%h daten=%h want 0/0/0", Fehler, Instruktion, DatenRein); end
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            checks++; if (DatenGespeichert !== 1'b0 || SpeicherSchreiben !== 1'b0) begin errors++;
                $display("FAIL rst_no_pulse[%0d]: got gesp=%b schr=%b want 0/0", i, DatenGespeichert, SpeicherSchreiben); end
        end
        DatenAdresse = 32'h70; LeseDaten = 1'b1;
        @(negedge Clock);
        checks++; if (SpeicherLesen !== 1'b1 || SpeicherAdresse !== 16'h0070) begin errors++;
            $display("FAIL rst_idle_accepts: got lesen=%b adr=%h want 1/0070", SpeicherLesen, SpeicherAdresse); end
        SpeicherBereit = 1'b1; SpeicherDatenLesen = 32'h31415926;
        @(negedge Clock);
        checks++; if (DatenGeladen !== 1'b1 || DatenRein !== 32'h31415926) begin errors++;
            $display("FAIL rst_load_done: got pulse=%b daten=%h want 1/31415926", DatenGeladen, DatenRein); end
        SpeicherBereit = 1'b0; LeseDaten = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_priority();
        test_slow_load();
        test_out_of_range();
        test_puffer();
        test_timeout();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
